action_value_table: RTL
=======================

Name: action_value_table

Overview:
Parametrised epsilon-greedy bandit agent: a table of 2^ACTION_WIDTH signed action values, with exact argmax selection by full table sweep and periodic pseudo-random exploration. It issues one action per decision over a valid/ready handshake, then waits for a reward. It updates the chosen entry as Q <- Q + (R - Q) >>> ALPHA_SHIFT. It is the generalised successor of the 8-bit action-value agent in the bandit datapath.

Parameters:
ACTION_WIDTH, 8, action index width; table depth N = 2^ACTION_WIDTH; legal range 2..12.
VALUE_WIDTH, 16, signed action-value width.
REWARD_WIDTH, 8, signed reward width; must be <= VALUE_WIDTH.
ALPHA_SHIFT, 3, learning-rate shift (alpha = 2^-ALPHA_SHIFT); legal range 0..VALUE_WIDTH-1.
EXPLORE_PERIOD, 16, one decision in EXPLORE_PERIOD explores; legal minimum 2.
SEED, all ones, ACTION_WIDTH-bit LFSR seed; must be nonzero.
TAPS, 8'hb1 for ACTION_WIDTH=8, ACTION_WIDTH-bit Fibonacci LFSR tap mask (maximal-length).
INIT, "", optional $readmemh file for the table.
INIT_VALUE, 0, signed fill value; used only with ACTION_VALUE_CLEAR_EN.

Ports:
clock  in  1  single clock; all logic on the rising edge
reset_n  in  1  synchronous, active-low reset
explore_inhibit  in  1  high suppresses exploration (always exploit)
reward_valid  in  1  reward handshake valid
reward_data  in  REWARD_WIDTH  signed reward for the last action
reward_ready  out  1  high only in OBSERVING
action_valid  out  1  high only in ACTUATING
action_data  out  ACTION_WIDTH  chosen action, stable while action_valid is high
action_explore  out  1  high when the current action came from exploration
action_ready  in  1  action handshake ready

Behaviour:
- Reset (reset_n low at an edge): state becomes DECIDING (or CLEARING with the feature); action_valid=0, reward_ready=0, action_data=0, action_explore=0; LFSR=SEED; explore counter=0; sweep index=0; utility=most-negative value.
- Reset never writes table contents (except through CLEARING). Reset in any state aborts the decision; any pending reward is discarded and no write occurs.
- LFSR: free-running, shifts left every cycle, new LSB = XOR of (lfsr & TAPS).
- Table read latency is 1 cycle. The table has one read port and one write port.
- DECIDING, exploit (explore_inhibit=1, or counter != EXPLORE_PERIOD-1), mode latched on entry:
  - Reads indices 0..N-1 sequentially, comparing each value the cycle after its read.
  - Index 0 is captured unconditionally; later indices are captured only on strict >, so the lowest index wins ties.
  - Lasts exactly N+1 cycles, then goes to ACTUATING with action_explore=0.
- DECIDING, explore (explore_inhibit=0 and counter == EXPLORE_PERIOD-1):
  - Samples the LFSR on the entry cycle as the action and reads its value.
  - Lasts exactly 2 cycles, then goes to ACTUATING with action_explore=1.
- ACTUATING: action_valid=1 and action_data held until action_ready=1. On the handshake, go to OBSERVING.
  - Counter increments on the handshake and wraps from EXPLORE_PERIOD-1 to 0.
- OBSERVING: reward_ready=1 until reward_valid=1. On that cycle:
  - write table[action] = update;
  - reset utility to most-negative; sweep index=0;
  - go to DECIDING next cycle.
- Update arithmetic:
  - reward is sign-extended to VALUE_WIDTH+1 bits;
  - diff = R - Q, computed in VALUE_WIDTH+1 bits;
  - arithmetic shift right by ALPHA_SHIFT;
  - add to Q, truncate to VALUE_WIDTH. The result always lies between Q and R, so it cannot overflow.
- The write in OBSERVING and any read never overlap, because reads occur only in DECIDING.
- action_valid and reward_ready are never high together.

Optional Feature:
ACTION_VALUE_CLEAR_EN
- Defined: after every reset, state CLEARING writes INIT_VALUE to entries 0..N-1, one per cycle (N cycles), with action_valid and reward_ready low, then enters DECIDING. Reset during CLEARING restarts at entry 0.
- Undefined: no CLEARING state. The table holds INIT file contents or prior contents across reset, and INIT_VALUE is ignored.

Test Plan:
- Argmax: INIT all -128 except table[0x2A]=100, explore_inhibit=1, release reset -> action_valid rises 257 cycles after DECIDING entry with action_data=0x2A, action_explore=0.
- Tie-break: table all 0 -> action_data=0x00. Then set table[0x05]=table[0x09]=7 -> action_data=0x05.
- Update: action 0x2A with Q=100, reward 127 -> table[0x2A]=103. Separately, Q=0 and reward -1 -> -1; Q=-128 and reward -128 -> -128 (unchanged).
- Handshake stalls: hold action_ready low 10 cycles -> action_valid and action_data stable throughout. Hold reward_valid low 10 cycles -> no table write, reward_ready stays 1.
- Exploration: explore_inhibit=0 -> 15 exploit decisions, then the 16th decision takes 2 DECIDING cycles with action_explore=1 and action_data = LFSR value sampled on the entry cycle; counter returns to 0. With explore_inhibit=1, 32 decisions all exploit.
- Reset mid-operation: assert reset_n=0 for 1 cycle while in OBSERVING with reward_valid=1 -> no write, outputs at reset values, new sweep begins. With ACTION_VALUE_CLEAR_EN, all N entries read back INIT_VALUE after N clear cycles.

Source files
------------

// File: rtl/action_value_table.sv
// Epsilon-greedy bandit agent: exploit picks the table argmax by full sweep (N+1 cycles), explore takes the LFSR (2 cycles).
// Action held until action_ready, reward awaited until reward_valid; define ACTION_VALUE_CLEAR_EN to clear the table after reset.
module action_value_table #(
   parameter int                             ACTION_WIDTH   = 8,
   parameter int                             VALUE_WIDTH    = 16,
   parameter int                             REWARD_WIDTH   = 8,
   parameter int                             ALPHA_SHIFT    = 3,
   parameter int                             EXPLORE_PERIOD = 16,
   parameter logic [ACTION_WIDTH-1:0]        SEED           = '1,
   parameter logic [ACTION_WIDTH-1:0]        TAPS           = 8'hb1,
   parameter string                          INIT           = "",
   parameter logic signed [VALUE_WIDTH-1:0]  INIT_VALUE     = '0
) (
   input  logic                    clock,
   input  logic                    reset_n,
   input  logic                    explore_inhibit,
   input  logic                    reward_valid,
   input  logic [REWARD_WIDTH-1:0] reward_data,
   output logic                    reward_ready,
   output logic                    action_valid,
   output logic [ACTION_WIDTH-1:0] action_data,
   output logic                    action_explore,
   input  logic                    action_ready
);
   localparam int N  = 1 << ACTION_WIDTH;
   localparam int CW = $clog2(EXPLORE_PERIOD);
   localparam logic [ACTION_WIDTH:0] LAST_IDX  = (ACTION_WIDTH + 1)'(N - 1);
   localparam logic [ACTION_WIDTH:0] SWEEP_END = (ACTION_WIDTH + 1)'(N);
   localparam logic signed [VALUE_WIDTH-1:0] MOST_NEG = {1'b1, {(VALUE_WIDTH - 1){1'b0}}};

   typedef enum logic [1:0] {CLEARING, DECIDING, ACTUATING, OBSERVING} state_t;
   state_t state, state_next;

   logic signed [VALUE_WIDTH-1:0] mem [N];
   logic signed [VALUE_WIDTH-1:0] rd_data, utility, wr_data, update;
   logic signed [VALUE_WIDTH:0]   reward_ext, diff, step;
   logic [ACTION_WIDTH-1:0]       rd_addr, wr_addr, lfsr, sweep_action;
   logic [ACTION_WIDTH:0]         idx;
   logic [CW-1:0]                 explore_cnt;
   logic wr_en, entry, cnt_last, explore_now, explore_mode, explore_sel, win;

   // idx doubles as the DECIDING cycle count, so idx==0 marks the entry cycle
   assign entry        = (idx == '0);
   assign cnt_last     = (explore_cnt == CW'(EXPLORE_PERIOD - 1));
   assign explore_now  = !explore_inhibit && cnt_last;
   assign explore_sel  = entry ? explore_now : explore_mode;
   assign sweep_action = ACTION_WIDTH'(idx - 1'b1);
   assign win          = (idx == (ACTION_WIDTH + 1)'(1)) || (rd_data > utility);

   // utility holds Q of the chosen action; the result lies between Q and R so truncation is exact
   assign reward_ext = {{(VALUE_WIDTH + 1 - REWARD_WIDTH){reward_data[REWARD_WIDTH-1]}}, reward_data};
   assign diff       = reward_ext - {utility[VALUE_WIDTH-1], utility};
   assign step       = diff >>> ALPHA_SHIFT;
   assign update     = VALUE_WIDTH'({utility[VALUE_WIDTH-1], utility} + step);

   assign action_valid = (state == ACTUATING);
   assign reward_ready = (state == OBSERVING);

   always_ff @(posedge clock) begin
      if (!reset_n) begin
`ifdef ACTION_VALUE_CLEAR_EN
         state <= CLEARING;
`else
         state <= DECIDING;
`endif
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      rd_addr    = idx[ACTION_WIDTH-1:0];
      wr_en      = 1'b0;
      wr_addr    = action_data;
      wr_data    = update;
      case (state)
`ifdef ACTION_VALUE_CLEAR_EN
         CLEARING: begin
            wr_en   = 1'b1;
            wr_addr = idx[ACTION_WIDTH-1:0];
            wr_data = INIT_VALUE;
            if (idx == LAST_IDX) state_next = DECIDING;
         end
`endif
         DECIDING: begin
            if (explore_sel) begin
               if (entry) rd_addr = lfsr;
               else       state_next = ACTUATING;
            end else if (idx == SWEEP_END) begin
               state_next = ACTUATING;
            end
         end
         ACTUATING: begin
            if (action_ready) state_next = OBSERVING;
         end
         OBSERVING: begin
            if (reward_valid) begin
               wr_en      = 1'b1;
               state_next = DECIDING;
            end
         end
         default: state_next = DECIDING;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         idx            <= '0;
         explore_cnt    <= '0;
         lfsr           <= SEED;
         utility        <= MOST_NEG;
         action_data    <= '0;
         action_explore <= 1'b0;
         explore_mode   <= 1'b0;
      end else begin
         lfsr <= {lfsr[ACTION_WIDTH-2:0], ^(lfsr & TAPS)};
         case (state)
            CLEARING: idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
            DECIDING: begin
               if (entry) begin
                  explore_mode   <= explore_now;
                  action_explore <= explore_now;
               end
               if (explore_sel) begin
                  if (entry) begin
                     action_data <= lfsr;
                     idx         <= idx + 1'b1;
                  end else begin
                     utility <= rd_data;
                     idx     <= '0;
                  end
               end else begin
                  // compare the entry read one cycle later; strict > keeps the lowest index on ties
                  if (!entry && win) begin
                     utility     <= rd_data;
                     action_data <= sweep_action;
                  end
                  idx <= (idx == SWEEP_END) ? '0 : idx + 1'b1;
               end
            end
            ACTUATING: begin
               if (action_ready) explore_cnt <= cnt_last ? '0 : explore_cnt + 1'b1;
            end
            OBSERVING: begin
               if (reward_valid) begin
                  utility <= MOST_NEG;
                  idx     <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (wr_en && reset_n) mem[wr_addr] <= wr_data;
      if (state == DECIDING) rd_data <= mem[rd_addr];
   end
endmodule
